// File: rtl/apb_mem_slave_pkg.sv
// Shared types and elaboration helpers for the APB scratch memory completer.
package apb_mem_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int strb_width(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between the decoder (master) and the memory completer (slave).
interface apb_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave_bytewr.sv
// DEPTH x DATA_WIDTH storage with a byte-enabled write port and a registered read port.
module apb_mem_bytewr #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                    pclk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on purpose: contents survive preset and the array maps onto plain RAM.
  always_ff @(posedge pclk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer over a byte-writable word memory with programmable wait states
// and pslverr on out-of-range word indices.
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input logic            pclk,
  input logic            preset,
  apb_mem_slave_if.slave bus
);
  localparam int NB  = strb_width(DATA_WIDTH);
  localparam int OFS = clog2(NB);
  localparam int IW  = ADDR_WIDTH - OFS;
  localparam int AW  = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  apb_state_e      state, state_nxt;
  logic [IW-1:0]   idx_q, cur_idx;
  logic            wr_q, oor_q, cur_oor;
  logic [3:0]      cnt, cnt_nxt;
  logic            pready_q, pready_nxt;
  logic            pslverr_q, pslverr_nxt;
  logic            rd_zero_q, rd_zero_nxt;
  logic            setup, done, we, re;
  logic [AW-1:0]   raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic            unused_paddr;

  assign cur_idx      = bus.paddr[ADDR_WIDTH-1:OFS];
  assign cur_oor      = 32'(cur_idx) >= DEPTH;
  assign unused_paddr = ^bus.paddr;
  assign setup        = (state == IDLE) && bus.psel && !bus.penable;
  assign done         = (state == ACCESS) && bus.psel && bus.penable && pready_q;

  // With zero wait states the read fires at the setup edge, before idx_q is loaded.
  assign raddr = (state == IDLE) ? cur_idx[AW-1:0] : idx_q[AW-1:0];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_zero_q <= 1'b1;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
      rd_zero_q <= rd_zero_nxt;
      if (setup) begin
        idx_q <= cur_idx;
        wr_q  <= bus.pwrite;
        oor_q <= cur_oor;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!bus.psel || done) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt;
    pready_nxt  = pready_q;
    pslverr_nxt = pslverr_q;
    rd_zero_nxt = rd_zero_q;
    we          = 1'b0;
    re          = 1'b0;
    case (state)
      IDLE: begin
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        if (setup) begin
          cnt_nxt = WS4;
          if (WAIT_STATES == 0) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = cur_oor;
            if (!bus.pwrite) begin
              re          = !cur_oor;
              rd_zero_nxt = cur_oor;
            end
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
          cnt_nxt     = '0;
        end else if (done) begin
          we          = wr_q && !oor_q;
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
        end else if (bus.penable && cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = oor_q;
            if (!wr_q) begin
              re          = !oor_q;
              rd_zero_nxt = oor_q;
            end
          end
        end
      end
    endcase
  end

  apb_mem_bytewr #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .pclk  (pclk),
    .we    (we),
    .waddr (idx_q[AW-1:0]),
    .wstrb (bus.pstrb),
    .wdata (bus.pwdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Out-of-range reads and reset both present zero without touching the RAM read register.
  assign bus.prdata  = rd_zero_q ? '0 : rdata;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
endmodule
